// File: rtl/dd_pkg.sv
// Shared types, geometry and flag codes for the display layer request path.
// Also holds the single-axis bounce step used by the sprite motion block.
package dd_pkg;

  typedef logic [10:0] coord_t;

  localparam coord_t H_ACT    = 11'd640;
  localparam coord_t V_ACT    = 11'd480;
  localparam coord_t BANNER_H = 11'd40;
  localparam coord_t BORDER   = 11'd8;
  localparam coord_t PX0      = 11'd100;
  localparam coord_t PX1      = 11'd540;
  localparam coord_t PY0      = 11'd100;
  localparam coord_t PY1      = 11'd380;
  localparam coord_t TX0      = 11'd200;
  localparam coord_t TX1      = 11'd440;
  localparam coord_t TY0      = 11'd400;
  localparam coord_t TY1      = 11'd464;
  localparam coord_t SPR_W    = 11'd32;
  localparam coord_t SPR_H    = 11'd32;
  localparam coord_t STEP     = 11'd4;
  localparam int     ANIM_DIV = 8;
  localparam int     ACW      = $clog2(ANIM_DIV);

  localparam coord_t XMIN = BORDER;
  localparam coord_t XMAX = H_ACT - BORDER - SPR_W;
  localparam coord_t YMIN = BANNER_H;
  localparam coord_t YMAX = V_ACT - BORDER - SPR_H;

  localparam logic [5:0] FLAG_NONE = 6'b000000;
  localparam logic [5:0] FLAG_L0   = 6'b100000;
  localparam logic [5:0] FLAG_L0L2 = 6'b101000;
  localparam logic [5:0] FLAG_L1   = 6'b010000;
  localparam logic [5:0] FLAG_L2   = 6'b001000;
  localparam logic [5:0] FLAG_L3   = 6'b000100;
  localparam logic [5:0] FLAG_S1   = 6'b000010;
  localparam logic [5:0] FLAG_S2   = 6'b000001;
  localparam logic [5:0] FLAG_S1L2 = 6'b001010;
  localparam logic [5:0] FLAG_S2L2 = 6'b001001;

  // Returns {new_dir, new_pos}; dir 1 = increasing. Sum is widened so it cannot wrap.
  function automatic logic [11:0] step_axis(
    input coord_t p,
    input logic   up,
    input coord_t lo,
    input coord_t hi
  );
    logic [11:0] r;
    if (up) begin
      if (({1'b0, p} + {1'b0, STEP}) > {1'b0, hi}) r = {~up, hi};
      else                                         r = {up, p + STEP};
    end else begin
      if (p < lo + STEP) r = {~up, lo};
      else               r = {up, p - STEP};
    end
    return r;
  endfunction

endpackage

// File: rtl/sprite_motion.sv
// Per-frame sprite position, bounce direction and animation phase state.
// Everything advances only on a qualified frame strobe.
import dd_pkg::*;

module sprite_motion (
  input  logic   clk,
  input  logic   rst,
  input  logic   adv,
  output coord_t spr_x,
  output coord_t spr_y,
  output logic   anim_sel
);

  coord_t          x_q, x_d;
  coord_t          y_q, y_d;
  logic            dx_q, dx_d;
  logic            dy_q, dy_d;
  logic [ACW-1:0]  cnt_q, cnt_d;
  logic            sel_q, sel_d;

  localparam logic [ACW-1:0] CNT_LAST = ACW'(ANIM_DIV - 1);

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    dx_d  = dx_q;
    dy_d  = dy_q;
    cnt_d = cnt_q;
    sel_d = sel_q;
    if (adv) begin
      {dx_d, x_d} = step_axis(x_q, dx_q, XMIN, XMAX);
      {dy_d, y_d} = step_axis(y_q, dy_q, YMIN, YMAX);
      if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
        sel_d = ~sel_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q   <= XMIN;
      y_q   <= YMIN;
      dx_q  <= 1'b1;
      dy_q  <= 1'b1;
      cnt_q <= '0;
      sel_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      cnt_q <= cnt_d;
      sel_q <= sel_d;
    end
  end

  assign spr_x    = x_q;
  assign spr_y    = y_q;
  assign anim_sel = sel_q;

endmodule

// File: rtl/layer_req_gen.sv
// Per-pixel layer ownership: hit tests on the timing counters, priority
// encoded into the request flags read by the layer colour selector.
import dd_pkg::*;

module layer_req_gen (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [10:0] hcnt,
  input  logic [10:0] vcnt,
  input  logic        frame_start,
  input  logic        run,
  output logic [5:0]  rq_flag,
  output logic [10:0] spr_x,
  output logic [10:0] spr_y
);

  logic       anim_sel;
  logic [5:0] rq_flag_q, rq_flag_d;
  logic       act, h0, h1, h2, h3, hs;

  sprite_motion u_motion (
    .clk      (clk),
    .rst      (rst),
    .adv      (frame_start & run),
    .spr_x    (spr_x),
    .spr_y    (spr_y),
    .anim_sel (anim_sel)
  );

  always_comb begin
    act = (hcnt < H_ACT) && (vcnt < V_ACT);
    h0  = vcnt < BANNER_H;
    h1  = (hcnt < BORDER) || (hcnt >= H_ACT - BORDER) ||
          (vcnt >= V_ACT - BORDER);
    h2  = (hcnt >= PX0) && (hcnt < PX1) &&
          (vcnt >= PY0) && (vcnt < PY1);
    h3  = (hcnt >= TX0) && (hcnt < TX1) &&
          (vcnt >= TY0) && (vcnt < TY1);
    hs  = (hcnt >= spr_x) && (hcnt < spr_x + SPR_W) &&
          (vcnt >= spr_y) && (vcnt < spr_y + SPR_H);
  end

  // Flags only change on a strobed pixel; otherwise the last code is held.
  always_comb begin
    rq_flag_d = rq_flag_q;
    if (pix_en) begin
      if (!act)          rq_flag_d = FLAG_NONE;
      else if (h0 && h2) rq_flag_d = FLAG_L0L2;
      else if (h0)       rq_flag_d = FLAG_L0;
      else if (h1)       rq_flag_d = FLAG_L1;
      else if (hs && h2) rq_flag_d = anim_sel ? FLAG_S2L2 : FLAG_S1L2;
      else if (hs)       rq_flag_d = anim_sel ? FLAG_S2 : FLAG_S1;
      else if (h3)       rq_flag_d = FLAG_L3;
      else if (h2)       rq_flag_d = FLAG_L2;
      else               rq_flag_d = FLAG_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rq_flag_q <= FLAG_NONE;
    else     rq_flag_q <= rq_flag_d;
  end

  assign rq_flag = rq_flag_q;

endmodule

// File: tb/tb_layer_req_gen.sv
// Bench for layer_req_gen: directed literals plus a randomized sweep
// compared every cycle against a behavioural screen/sprite model.
module tb_layer_req_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [10:0] hcnt;
  logic [10:0] vcnt;
  logic        frame_start;
  logic        run;
  logic [5:0]  rq_flag;
  logic [10:0] spr_x;
  logic [10:0] spr_y;

  int checks = 0;
  int errors = 0;

  // model state
  int  m_sx, m_sy, m_dx, m_dy, m_cnt, m_sel;
  int  m_flag;
  bit  m_valid = 0;

  always #5 clk = ~clk;

  layer_req_gen dut (
    .clk         (clk),
    .rst         (rst),
    .pix_en      (pix_en),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start),
    .run         (run),
    .rq_flag     (rq_flag),
    .spr_x       (spr_x),
    .spr_y       (spr_y)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int model_flag(input int h, input int v);
    bit h0, h1, h2, h3, hs;
    if (!(h < 640 && v < 480)) return 0;
    h0 = v < 40;
    h1 = (h < 8) || (h >= 632) || (v >= 472);
    h2 = (h >= 100 && h < 540 && v >= 100 && v < 380);
    h3 = (h >= 200 && h < 440 && v >= 400 && v < 464);
    hs = (h >= m_sx && h < m_sx + 32 && v >= m_sy && v < m_sy + 32);
    if (h0 && h2) return 'b101000;
    if (h0)       return 'b100000;
    if (h1)       return 'b010000;
    if (hs && h2) return m_sel ? 'b001001 : 'b001010;
    if (hs)       return m_sel ? 'b000001 : 'b000010;
    if (h3)       return 'b000100;
    if (h2)       return 'b001000;
    return 0;
  endfunction

  function automatic bit legal(input int f);
    return f inside {'b000000, 'b100000, 'b101000, 'b010000, 'b001000,
                     'b000100, 'b000010, 'b000001, 'b001010, 'b001001};
  endfunction

  // model update and per-cycle compare
  always @(posedge clk) begin
    if (rst) begin
      m_sx = 8; m_sy = 40; m_dx = 1; m_dy = 1;
      m_cnt = 0; m_sel = 0; m_flag = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (pix_en) m_flag = model_flag(int'(hcnt), int'(vcnt));
      if (frame_start && run) begin
        if (m_dx > 0) begin
          if (m_sx + 4 > 600) begin m_sx = 600; m_dx = -1; end
          else m_sx += 4;
        end else begin
          if (m_sx - 4 < 8) begin m_sx = 8; m_dx = 1; end
          else m_sx -= 4;
        end
        if (m_dy > 0) begin
          if (m_sy + 4 > 440) begin m_sy = 440; m_dy = -1; end
          else m_sy += 4;
        end else begin
          if (m_sy - 4 < 40) begin m_sy = 40; m_dy = 1; end
          else m_sy -= 4;
        end
        m_cnt = (m_cnt + 1) % 8;
        if (m_cnt == 0) m_sel ^= 1;
      end
    end
    #1;
    if (m_valid) begin
      chk("cyc_flag", int'(rq_flag), m_flag);
      chk("cyc_sprx", int'(spr_x), m_sx);
      chk("cyc_spry", int'(spr_y), m_sy);
      chk("cyc_legal", int'(legal(int'(rq_flag))), 1);
    end
  end

  task automatic pixel(input int h, input int v, input int exp, input string nm);
    @(negedge clk);
    pix_en = 1; hcnt = 11'(h); vcnt = 11'(v);
    @(negedge clk);
    pix_en = 0;
    chk(nm, int'(rq_flag), exp);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk); frame_start = 1;
      @(negedge clk); frame_start = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
  endtask

  initial begin
    rst = 1; pix_en = 0; hcnt = 0; vcnt = 0; frame_start = 0; run = 1;
    repeat (2) @(negedge clk);
    chk("reset_flag", int'(rq_flag), 0);
    chk("reset_x", int'(spr_x), 8);
    chk("reset_y", int'(spr_y), 40);
    rst = 0;

    pixel(0, 0, 'b100000, "banner");
    pixel(3, 200, 'b010000, "border");
    pixel(320, 420, 'b000100, "textbox");
    pixel(320, 200, 'b001000, "panel");
    pixel(50, 300, 'b000000, "bg");
    pixel(700, 10, 'b000000, "inactive");

    pixel(10, 45, 'b000010, "spr_f1");
    frames(1);
    chk("move1_x", int'(spr_x), 12);
    chk("move1_y", int'(spr_y), 44);
    frames(7);
    pixel(10, 45, 'b000000, "spr_gone");
    pixel(50, 80, 'b000001, "spr_f2");

    frames(22);
    pixel(130, 162, 'b001001, "spr2_panel");
    frames(2);
    pixel(140, 170, 'b001010, "spr1_panel");
    pixel(320, 420, 'b000100, "textbox2");
    pixel(500, 300, 'b001000, "panel2");

    do_reset();
    frames(100);
    chk("y_top", int'(spr_y), 440);
    chk("x_at100", int'(spr_x), 408);
    frames(2);
    chk("y_back", int'(spr_y), 436);
    frames(46);
    chk("x_148", int'(spr_x), 600);
    frames(1);
    chk("x_149", int'(spr_x), 600);
    frames(1);
    chk("x_150", int'(spr_x), 596);
    chk("y_150", int'(spr_y), 244);

    run = 0;
    frames(20);
    chk("frz_x", int'(spr_x), 596);
    chk("frz_y", int'(spr_y), 244);
    pixel(600, 250, 'b000010, "frz_anim");
    run = 1;
    frames(2);
    pixel(600, 250, 'b000001, "anim_after");

    pixel(320, 200, 'b001000, "hold_pre");
    @(negedge clk); hcnt = 0; vcnt = 0;
    repeat (4) @(negedge clk);
    chk("hold", int'(rq_flag), 'b001000);

    @(negedge clk); rst = 1; pix_en = 1; hcnt = 320; vcnt = 200;
    @(negedge clk); rst = 0; pix_en = 0;
    chk("midrst_flag", int'(rq_flag), 0);
    chk("midrst_x", int'(spr_x), 8);
    chk("midrst_y", int'(spr_y), 40);

    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      pix_en      = ($urandom_range(0, 3) != 0);
      frame_start = ($urandom_range(0, 15) == 0);
      run         = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 2) == 0) begin
        hcnt = 11'(m_sx + $urandom_range(0, 40) - 4);
        vcnt = 11'(m_sy + $urandom_range(0, 40) - 4);
      end else begin
        hcnt = 11'($urandom_range(0, 800));
        vcnt = 11'($urandom_range(0, 600));
      end
    end
    @(negedge clk);
    pix_en = 0; frame_start = 0;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
